// File: rtl/perf_pkg.sv
// Shared types and constants for the performance-counter bank.
package perf_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    localparam int SEL_CYCLE   = 0;
    localparam int SEL_INSTRET = 1;
    localparam int SEL_EVT0    = 2;

    localparam int DEFAULT_CNT_W   = 32;
    localparam int DEFAULT_TIMEOUT = 100000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over the enable.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Once all ones the count holds instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (en && (r_q != {W{1'b1}})) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Cycle / retire / event counter bank that freezes on halt or cycle-budget timeout.
// Optional PERF_REPORT_EN prints a one-line summary and ends simulation when the run ends.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int CNT_W   = DEFAULT_CNT_W,
    parameter int N_EVT   = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        halt,
    input  logic                        W_v,
    input  logic [N_EVT-1:0]            evt_v,
    input  logic [$clog2(N_EVT+2)-1:0]  rd_sel,
    output logic [CNT_W-1:0]            rd_data,
    output logic [CNT_W-1:0]            cycle,
    output logic                        done,
    output logic                        timed_out
);

    localparam int N_CNT = N_EVT + 2;
    localparam int SEL_W = $clog2(N_EVT + 2);
    localparam logic [63:0] TIMEOUT_LAST = 64'(TIMEOUT - 1);

    state_t             r_state;
    logic               r_done;
    logic               r_timed_out;
    logic [CNT_W-1:0]   r_rd_data;
    logic [CNT_W-1:0]   w_rd_mux;
    logic [N_CNT-1:0]   w_en;
    logic [CNT_W-1:0]   w_cnt [N_CNT];
    logic               w_run;
    logic               w_timeout;

    assign w_run = (r_state == RUN);
    assign w_en[SEL_CYCLE]   = w_run;
    assign w_en[SEL_INSTRET] = w_run & W_v;

    for (genvar k = 0; k < N_EVT; k++) begin : g_evt_en
        assign w_en[SEL_EVT0+k] = w_run & evt_v[k];
    end

    for (genvar g = 0; g < N_CNT; g++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .en    (w_en[g]),
            .q     (w_cnt[g])
        );
    end

    // Wide compare so a budget beyond the counter range simply never fires.
    assign w_timeout = (64'(w_cnt[SEL_CYCLE]) == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_done      <= 1'b0;
            r_timed_out <= 1'b0;
        end else if (clr) begin
            r_state     <= RUN;
            r_done      <= 1'b0;
            r_timed_out <= 1'b0;
        end else if (r_state == RUN) begin
            if (halt) begin
                r_state     <= DONE;
                r_done      <= 1'b1;
                r_timed_out <= 1'b0;
            end else if (w_timeout) begin
                r_state     <= DONE;
                r_done      <= 1'b1;
                r_timed_out <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        for (int k = 0; k < N_CNT; k++) begin
            if (rd_sel == SEL_W'(k)) begin
                w_rd_mux = w_cnt[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign rd_data   = r_rd_data;
    assign cycle     = w_cnt[SEL_CYCLE];
    assign done      = r_done;
    assign timed_out = r_timed_out;

`ifdef PERF_REPORT_EN
    logic r_done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_d <= 1'b0;
        end else begin
            r_done_d <= r_done;
        end
    end

    // Counters are frozen once done is high, so reporting one edge later sees final values.
    always @(posedge clk) begin
        if (rst_n && r_done && !r_done_d && !clr) begin
            if (r_timed_out) begin
                $display("#ran for %0d cycles", TIMEOUT);
            end else begin
                $write("cycles=%0d instret=%0d ", w_cnt[SEL_CYCLE], w_cnt[SEL_INSTRET]);
                if (w_cnt[SEL_INSTRET] == '0) begin
                    $write("CPI=n/a");
                end else begin
                    $write("CPI=%f", real'(w_cnt[SEL_CYCLE]) / real'(w_cnt[SEL_INSTRET]));
                end
                for (int k = 0; k < N_EVT; k++) begin
                    $write(" evt%0d=%0d", k, w_cnt[SEL_EVT0+k]);
                end
                $display("");
            end
            $finish;
        end
    end
`endif

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Parametrised performance-counter bank for the pipelined core testbench. It counts cycles, retired instructions and N_EVT generic event channels (stalls, flushes, cache misses, etc.). It stops on halt or on a cycle-budget timeout, and exposes frozen results through a registered read port. It sits beside the writeback stage and takes the writeback-valid strobe as its retire input.

## Interface
Parameters:
- CNT_W, 32: width of every counter.
- N_EVT, 4: number of generic event channels (1..16).
- TIMEOUT, 100000: cycle budget; reaching it ends the run.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset. Asynchronous assert, active-low, clears all state.
- clr  in  1  synchronous clear of all counters; returns the block to RUN.
- halt  in  1  core halt indication.
- W_v  in  1  writeback valid; one retired instruction per asserted cycle.
- evt_v  in  N_EVT  per-channel event strobe; one count per asserted cycle.
- rd_sel  in  $clog2(N_EVT+2)  select: 0 = cycle, 1 = instret, 2+k = event k.
- rd_data  out  CNT_W  registered read data.
- cycle  out  CNT_W  live cycle counter.
- done  out  1  run ended; counters frozen.
- timed_out  out  1  run ended by TIMEOUT rather than halt.

## Operation
- States: RUN, DONE. Reset and clr both enter RUN.
- RUN behaviour:
  - cycle increments every clock.
  - instret increments when W_v=1.
  - evt[k] increments when evt_v[k]=1.
- Saturation: all counters saturate at 2^CNT_W-1. A saturated counter holds and does not wrap.
- RUN to DONE on halt: when halt=1 in RUN, the block goes to DONE, done=1, timed_out=0. Strobes in that same cycle are counted; cycle includes that cycle.
- RUN to DONE on timeout: when halt=0 and the cycle counter equals TIMEOUT-1, the increment is applied, then the block goes to DONE with timed_out=1. Final cycle = TIMEOUT.
- Simultaneous halt and timeout: halt wins, timed_out=0.
- DONE: all counters frozen. W_v, evt_v and halt are ignored. The block stays in DONE until clr or reset.
- clr priority: clr overrides everything else in the same cycle. All counters go to 0, the state goes to RUN, and done and timed_out go to 0. Strobes in the clr cycle are not counted.
- Read port: rd_data is updated every cycle in both states.
  - rd_sel ≥ N_EVT+2 returns 0.

## Timing
- Reset values: cycle=0, rd_data=0, done=0, timed_out=0, every counter 0, state RUN.
- Reset mid-run: the asynchronous assert clears everything immediately. The first count occurs on the first rising edge after rst_n deasserts.
- Counter latency: a strobe sampled at edge t is visible on cycle (or via the read port) after edge t.
- done timing: done rises on the edge that samples the terminating condition.
- Read latency: rd_data reflects the selected counter's value after edge t−1, registered at edge t (one-cycle read latency).

## Configuration
- PERF_REPORT_EN defined: on the cycle done rises, print one line with cycles, instret, CPI and each event count, then call $finish. Also:
  - CPI uses real division of cycle by instret.
  - instret=0 prints "CPI=n/a".
  - If timed_out is set, print "#ran for <TIMEOUT> cycles" instead.
- PERF_REPORT_EN undefined: no system tasks and no $finish. The block is fully synthesisable; the environment polls done and reads counters through rd_sel.

## Structure
- Package perf_pkg:
  - state enum {RUN, DONE}.
  - rd_sel constants SEL_CYCLE=0, SEL_INSTRET=1, SEL_EVT0=2.
  - Default CNT_W and TIMEOUT constants.
- Sub-module sat_counter (parameter W):
  - Ports: clk, rst_n, clr, en, q.
  - Saturating increment.
  - Instantiated N_EVT+2 times; the top holds the FSM, the enables and the read mux.

## Test plan
- Retire and halt: reset, W_v=1 for 10 cycles, then halt at cycle 20 → done=1, timed_out=0, cycle=21, instret=10. With PERF_REPORT_EN, the printed CPI is 2.100000.
- Timeout: TIMEOUT=50, halt never asserted → done rises when cycle=50, timed_out=1. W_v pulses after that are not counted.
- Halt and timeout together: TIMEOUT=50, halt asserted on the cycle where cycle=49 → timed_out=0, cycle=50.
- Saturation: CNT_W=4, evt_v[0]=1 for 20 cycles → evt0 holds at 15. Read with rd_sel=2 returns 15 one cycle later.
- Clear and reset: clr in DONE → all counters 0 and done=0 next cycle, and counting resumes. rst_n pulled low mid-run → outputs 0 immediately.
- Invalid read select: rd_sel=N_EVT+2 → rd_data=0.
